// File: rtl/spart_rx.sv
// SPART receive path: 8N1 deserializer with 16x oversampling off the shared baud divisor.
// Presents each byte with rda / framing_err / overrun flags to the bus side.
`timescale 1ns/1ps
module spart_rx #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [15:0] divisor,
  input  logic        rx_rd,
  output logic [7:0]  rx_data,
  output logic        rda,
  output logic        framing_err,
  output logic        overrun,
  output logic        rx_busy
);

  localparam int unsigned DIV_W = 16;
  localparam int unsigned TCW   = 4;
  localparam int unsigned BCW   = 3;
  localparam int unsigned DW    = 8;
  localparam logic [TCW-1:0] TC_MID = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TC_END = TCW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DIV_W-1:0]       r_baud;
  state_t                 r_state;
  logic [TCW-1:0]         r_tcnt;
  logic [BCW-1:0]         r_bcnt;
  logic [DW-1:0]          r_shift;
  logic                   r_line_ok;

  logic                   w_rxs;
  logic                   w_tick;
  logic [DIV_W-1:0]       w_reload;
  state_t                 w_state_nxt;
  logic [TCW-1:0]         w_tcnt_nxt;
  logic [BCW-1:0]         w_bcnt_nxt;
  logic [DW-1:0]          w_shift_nxt;
  logic                   w_complete;

  // rxd metastability synchronizer; resets to the idle-high line level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '1;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
  end

  assign w_rxs = r_sync[SYNC_STAGES-1];

  // Free-running baud tick down-counter; divisor 0 and 1 both give a tick every clk
  assign w_tick   = (r_baud == '0);
  assign w_reload = (divisor <= DIV_W'(1)) ? '0 : divisor - DIV_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_baud <= '0;
    else if (w_tick) r_baud <= w_reload;
    else             r_baud <= r_baud - DIV_W'(1);
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_bcnt_nxt  = r_bcnt;
    w_shift_nxt = r_shift;
    w_complete  = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxs && r_line_ok) begin
            w_state_nxt = S_START;
            w_tcnt_nxt  = '0;
          end
        end
        S_START: begin
          if (r_tcnt == TC_MID) begin
            w_tcnt_nxt = '0;
            if (!w_rxs) begin
              w_state_nxt = S_DATA;
              w_bcnt_nxt  = '0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + TCW'(1);
          end
        end
        S_DATA: begin
          if (r_tcnt == TC_END) begin
            w_shift_nxt = {w_rxs, r_shift[DW-1:1]};
            w_tcnt_nxt  = '0;
            w_bcnt_nxt  = r_bcnt + BCW'(1);
            if (r_bcnt == BCW'(DW - 1)) w_state_nxt = S_STOP;
          end else begin
            w_tcnt_nxt = r_tcnt + TCW'(1);
          end
        end
        S_STOP: begin
          if (r_tcnt == TC_END) begin
            w_state_nxt = S_IDLE;
            w_tcnt_nxt  = '0;
            w_complete  = 1'b1;
          end else begin
            w_tcnt_nxt = r_tcnt + TCW'(1);
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Bus-facing flags; a completing frame takes priority over a concurrent read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else if (w_complete) begin
      rx_data     <= r_shift;
      rda         <= 1'b1;
      framing_err <= ~w_rxs;
      overrun     <= rda & ~rx_rd;
    end else if (rx_rd && rda) begin
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end
  end

  // A stuck-low line after a bad stop bit must go high before another start is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       r_line_ok <= 1'b1;
    else if (w_tick && w_rxs)       r_line_ok <= 1'b1;
    else if (w_complete && !w_rxs)  r_line_ok <= 1'b0;
  end

  assign rx_busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_spart_rx.sv
// Directed bench for spart_rx: frames are driven bit-by-bit on rxd and
// the received byte and flags are compared against hand-computed values.
`timescale 1ns/1ps
module tb_spart_rx;

  localparam int BIT4 = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxd = 1'b1;
  logic        rx_rd = 1'b0;
  logic [15:0] divisor = 16'd4;
  logic [7:0]  rx_data;
  logic        rda;
  logic        framing_err;
  logic        overrun;
  logic        rx_busy;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rel_cyc = 0;

  spart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .divisor(divisor), .rx_rd(rx_rd),
    .rx_data(rx_data), .rda(rda), .framing_err(framing_err),
    .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance n rising edges, then settle 1ns past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int bc);
    rxd = 1'b0;
    step(bc);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      step(bc);
    end
    rxd = stop;
    step(bc);
  endtask

  task automatic pulse_rd();
    rx_rd = 1'b1;
    step(1);
    rx_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    divisor = 16'd4;
    step(3);
    n_chk++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h exp 00", rx_data); else n_pass++;
    n_chk++; if (rda !== 1'b0) $display("FAIL reset_rda: got %b exp 0", rda); else n_pass++;
    n_chk++; if (framing_err !== 1'b0) $display("FAIL reset_fe: got %b exp 0", framing_err); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL reset_ov: got %b exp 0", overrun); else n_pass++;
    n_chk++; if (rx_busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", rx_busy); else n_pass++;
    rst = 1'b1;
    rel_cyc = cyc + 1;
    step(20);
  endtask

  task automatic test_basic();
    int s;
    int lat;
    lat = -1;
    s = cyc;
    fork
      send_frame(8'h55, 1'b1, BIT4);
      begin
        for (int k = 0; k < 700; k++) begin
          @(negedge clk);
          if (rda === 1'b1 && lat < 0) lat = cyc - s;
        end
      end
    join
    step(1);
    n_chk++; if (lat < 608 || lat > 616) $display("FAIL basic_latency: got %0d exp 608..616", lat); else n_pass++;
    n_chk++; if (rx_data !== 8'h55) $display("FAIL basic_data: got %h exp 55", rx_data); else n_pass++;
    n_chk++; if (rda !== 1'b1) $display("FAIL basic_rda: got %b exp 1", rda); else n_pass++;
    n_chk++; if (framing_err !== 1'b0) $display("FAIL basic_fe: got %b exp 0", framing_err); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL basic_ov: got %b exp 0", overrun); else n_pass++;
    n_chk++; if (rx_busy !== 1'b0) $display("FAIL basic_busy: got %b exp 0", rx_busy); else n_pass++;
    pulse_rd();
    step(2);
    n_chk++; if (rda !== 1'b0) $display("FAIL rd_clear_rda: got %b exp 0", rda); else n_pass++;
    n_chk++; if (rx_data !== 8'h55) $display("FAIL rd_hold_data: got %h exp 55", rx_data); else n_pass++;
  endtask

  task automatic test_false_start();
    rxd = 1'b0;
    step(16);
    n_chk++; if (rx_busy !== 1'b1) $display("FAIL false_busy_mid: got %b exp 1", rx_busy); else n_pass++;
    rxd = 1'b1;
    step(200);
    n_chk++; if (rda !== 1'b0) $display("FAIL false_rda: got %b exp 0", rda); else n_pass++;
    n_chk++; if (rx_data !== 8'h55) $display("FAIL false_data: got %h exp 55", rx_data); else n_pass++;
    n_chk++; if (rx_busy !== 1'b0) $display("FAIL false_busy_end: got %b exp 0", rx_busy); else n_pass++;
  endtask

  task automatic test_framing();
    send_frame(8'hA3, 1'b0, BIT4);
    rxd = 1'b0;
    step(200);
    n_chk++; if (rda !== 1'b1) $display("FAIL fe_rda: got %b exp 1", rda); else n_pass++;
    n_chk++; if (rx_data !== 8'hA3) $display("FAIL fe_data: got %h exp a3", rx_data); else n_pass++;
    n_chk++; if (framing_err !== 1'b1) $display("FAIL fe_flag: got %b exp 1", framing_err); else n_pass++;
    n_chk++; if (rx_busy !== 1'b0) $display("FAIL fe_no_restart: got %b exp 0", rx_busy); else n_pass++;
    pulse_rd();
    rxd = 1'b1;
    step(BIT4);
    send_frame(8'h0F, 1'b1, BIT4);
    step(8);
    n_chk++; if (rx_data !== 8'h0F) $display("FAIL fe_next_data: got %h exp 0f", rx_data); else n_pass++;
    n_chk++; if (rda !== 1'b1) $display("FAIL fe_next_rda: got %b exp 1", rda); else n_pass++;
    n_chk++; if (framing_err !== 1'b0) $display("FAIL fe_next_fe: got %b exp 0", framing_err); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL fe_next_ov: got %b exp 0", overrun); else n_pass++;
  endtask

  task automatic test_back_to_back();
    pulse_rd();
    step(4);
    send_frame(8'h01, 1'b1, BIT4);
    send_frame(8'h02, 1'b1, BIT4);
    step(8);
    n_chk++; if (rx_data !== 8'h02) $display("FAIL ovr_data: got %h exp 02", rx_data); else n_pass++;
    n_chk++; if (rda !== 1'b1) $display("FAIL ovr_rda: got %b exp 1", rda); else n_pass++;
    n_chk++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b exp 1", overrun); else n_pass++;
    n_chk++; if (framing_err !== 1'b0) $display("FAIL ovr_fe: got %b exp 0", framing_err); else n_pass++;
    pulse_rd();
    step(2);
    n_chk++; if (rda !== 1'b0) $display("FAIL ovr_rd_rda: got %b exp 0", rda); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL ovr_rd_ov: got %b exp 0", overrun); else n_pass++;
    n_chk++; if (framing_err !== 1'b0) $display("FAIL ovr_rd_fe: got %b exp 0", framing_err); else n_pass++;
    n_chk++; if (rx_data !== 8'h02) $display("FAIL ovr_rd_data: got %h exp 02", rx_data); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    rxd = 1'b0;
    step(BIT4);
    rxd = 1'b1;
    step(3 * BIT4 + 32);
    n_chk++; if (rx_busy !== 1'b1) $display("FAIL mid_busy_pre: got %b exp 1", rx_busy); else n_pass++;
    rst = 1'b0;
    #2;
    n_chk++; if (rx_busy !== 1'b0) $display("FAIL mid_rst_busy: got %b exp 0", rx_busy); else n_pass++;
    n_chk++; if (rx_data !== 8'h00) $display("FAIL mid_rst_data: got %h exp 00", rx_data); else n_pass++;
    n_chk++; if (rda !== 1'b0) $display("FAIL mid_rst_rda: got %b exp 0", rda); else n_pass++;
    n_chk++; if (framing_err !== 1'b0 || overrun !== 1'b0)
      $display("FAIL mid_rst_flags: got fe=%b ov=%b exp 0 0", framing_err, overrun); else n_pass++;
    step(4);
    rst = 1'b1;
    rel_cyc = cyc + 1;
    step(BIT4);
    send_frame(8'h3C, 1'b1, BIT4);
    step(8);
    n_chk++; if (rx_data !== 8'h3C) $display("FAIL post_rst_data: got %h exp 3c", rx_data); else n_pass++;
    n_chk++; if (rda !== 1'b1) $display("FAIL post_rst_rda: got %b exp 1", rda); else n_pass++;
    n_chk++; if (framing_err !== 1'b0 || overrun !== 1'b0)
      $display("FAIL post_rst_flags: got fe=%b ov=%b exp 0 0", framing_err, overrun); else n_pass++;
  endtask

  // Start edge placed so the first tick sees rxs low; completion lands 611 clks later
  task automatic test_rd_at_completion();
    int s;
    int c;
    while (((cyc + 3 - rel_cyc) % 4) != 0) step(1);
    s = cyc;
    c = s + 611;
    fork
      send_frame(8'h7E, 1'b1, BIT4);
      begin
        while (cyc < c - 1) step(1);
        n_chk++; if (rda !== 1'b1 || rx_data !== 8'h3C)
          $display("FAIL cmp_pre: got rda=%b data=%h exp 1 3c", rda, rx_data); else n_pass++;
        rx_rd = 1'b1;
        step(1);
        rx_rd = 1'b0;
      end
    join
    step(2);
    n_chk++; if (rda !== 1'b1) $display("FAIL cmp_rda: got %b exp 1", rda); else n_pass++;
    n_chk++; if (rx_data !== 8'h7E) $display("FAIL cmp_data: got %h exp 7e", rx_data); else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL cmp_ov: got %b exp 0", overrun); else n_pass++;
    n_chk++; if (framing_err !== 1'b0) $display("FAIL cmp_fe: got %b exp 0", framing_err); else n_pass++;
  endtask

  task automatic test_divisor_zero();
    pulse_rd();
    divisor = 16'd0;
    step(8);
    send_frame(8'hC9, 1'b1, 16);
    step(8);
    n_chk++; if (rx_data !== 8'hC9) $display("FAIL div0_data: got %h exp c9", rx_data); else n_pass++;
    n_chk++; if (rda !== 1'b1) $display("FAIL div0_rda: got %b exp 1", rda); else n_pass++;
    n_chk++; if (framing_err !== 1'b0 || overrun !== 1'b0)
      $display("FAIL div0_flags: got fe=%b ov=%b exp 0 0", framing_err, overrun); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_framing();
    test_back_to_back();
    test_reset_midframe();
    test_rd_at_completion();
    test_divisor_zero();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
